// File: rtl/main_control_fsm_pkg.sv
// Shared types for the multicycle main controller:
// state encoding, opcodes, datapath select encodings.
package main_control_fsm_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMREAD,
        MEMWB,
        MEMWRITE,
        EXECR,
        ALUWB,
        BEQ,
        ILLEGAL,
        TIMEOUT
    } ctrl_state_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10
    } alu_op_e;

    typedef enum logic [1:0] {
        SRCA_PC     = 2'b00,
        SRCA_OLD_PC = 2'b01,
        SRCA_RS1    = 2'b10
    } alu_src_a_e;

    typedef enum logic [1:0] {
        SRCB_RS2  = 2'b00,
        SRCB_IMM  = 2'b01,
        SRCB_FOUR = 2'b10
    } alu_src_b_e;

    typedef enum logic [1:0] {
        RES_ALU_OUT  = 2'b00,
        RES_MEM_DATA = 2'b01,
        RES_ALU      = 2'b10
    } result_src_e;

    typedef struct packed {
        logic        mem_req;
        logic        mem_write;
        logic        adr_src;
        logic        ir_write;
        logic        pc_write;
        logic        reg_write;
        alu_src_a_e  alu_src_a;
        alu_src_b_e  alu_src_b;
        result_src_e result_src;
        alu_op_e     alu_op;
        logic        instr_retired;
        logic        illegal_instr;
        logic        mem_timeout;
    } ctrl_out_t;

    function automatic logic is_mem_state(ctrl_state_e s);
        return (s == FETCH) || (s == MEMREAD) || (s == MEMWRITE);
    endfunction

endpackage

// File: rtl/main_control_fsm_if.sv
// Shared memory port handshake between the
// main controller (master) and memory (slave).
interface main_control_fsm_if;
    logic mem_req;
    logic mem_write;
    logic mem_ready;

    modport master (
        output mem_req,
        output mem_write,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_write,
        output mem_ready
    );
endinterface

// File: rtl/main_control_fsm_mem_wait_timer.sv
// Saturating wait counter for memory accesses;
// expired flags that LIMIT waiting cycles have elapsed.
module mem_wait_timer #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic cnt_en,
    output logic expired
);
    localparam int unsigned W = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;
    localparam logic [W-1:0] LIM = W'(LIMIT);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (cnt_en && (cnt_q != LIM)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // LIMIT of 0 disables the timeout entirely
    assign expired = (LIMIT != 0) && (cnt_q == LIM);
endmodule

// File: rtl/main_control_fsm.sv
// Multicycle main controller: sequences fetch/decode/execute
// and handshakes with the shared memory port.
module main_control_fsm
    import main_control_fsm_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [6:0]         op,
    input  logic               zero,
    main_control_fsm_if.master mem,
    output logic               adr_src,
    output logic               ir_write,
    output logic               pc_write,
    output logic               reg_write,
    output logic [1:0]         alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         result_src,
    output logic [1:0]         alu_op,
    output logic               instr_retired,
    output logic               illegal_instr,
    output logic               mem_timeout
);
    ctrl_state_e state_q;
    ctrl_state_e state_d;
    ctrl_out_t   ctrl;
    logic        in_mem;
    logic        expired;

    assign in_mem = is_mem_state(state_q);

    mem_wait_timer #(
        .LIMIT(MEM_TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (!in_mem || mem.mem_ready),
        .cnt_en (in_mem && !mem.mem_ready),
        .expired(expired)
    );

    // mem_ready wins over an expiring timer in the same cycle
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FETCH: begin
                if (mem.mem_ready) state_d = DECODE;
                else if (expired)  state_d = TIMEOUT;
            end
            DECODE: begin
                unique case (1'b1)
                    (op == OP_LOAD),
                    (op == OP_STORE):  state_d = MEMADR;
                    (op == OP_RTYPE):  state_d = EXECR;
                    (op == OP_BRANCH): state_d = BEQ;
                    default:           state_d = ILLEGAL;
                endcase
            end
            MEMADR: begin
                state_d = (op == OP_LOAD) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                if (mem.mem_ready) state_d = MEMWB;
                else if (expired)  state_d = TIMEOUT;
            end
            MEMWRITE: begin
                if (mem.mem_ready) state_d = FETCH;
                else if (expired)  state_d = TIMEOUT;
            end
            EXECR:   state_d = ALUWB;
            MEMWB,
            ALUWB,
            BEQ:     state_d = FETCH;
            ILLEGAL: state_d = ILLEGAL;
            TIMEOUT: state_d = TIMEOUT;
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        ctrl = '0;
        if (rst_n) begin
            unique case (state_q)
                FETCH: begin
                    ctrl.mem_req    = 1'b1;
                    ctrl.alu_src_a  = SRCA_PC;
                    ctrl.alu_src_b  = SRCB_FOUR;
                    ctrl.alu_op     = ALU_ADD;
                    ctrl.result_src = RES_ALU;
                    ctrl.ir_write   = mem.mem_ready;
                    ctrl.pc_write   = mem.mem_ready;
                end
                DECODE: begin
                    ctrl.alu_src_a = SRCA_OLD_PC;
                    ctrl.alu_src_b = SRCB_IMM;
                    ctrl.alu_op    = ALU_ADD;
                end
                MEMADR: begin
                    ctrl.alu_src_a = SRCA_RS1;
                    ctrl.alu_src_b = SRCB_IMM;
                    ctrl.alu_op    = ALU_ADD;
                end
                MEMREAD: begin
                    ctrl.mem_req = 1'b1;
                    ctrl.adr_src = 1'b1;
                end
                MEMWB: begin
                    ctrl.result_src    = RES_MEM_DATA;
                    ctrl.reg_write     = 1'b1;
                    ctrl.instr_retired = 1'b1;
                end
                MEMWRITE: begin
                    ctrl.mem_req       = 1'b1;
                    ctrl.mem_write     = 1'b1;
                    ctrl.adr_src       = 1'b1;
                    ctrl.instr_retired = mem.mem_ready;
                end
                EXECR: begin
                    ctrl.alu_src_a = SRCA_RS1;
                    ctrl.alu_src_b = SRCB_RS2;
                    ctrl.alu_op    = ALU_FUNCT;
                end
                ALUWB: begin
                    ctrl.result_src    = RES_ALU_OUT;
                    ctrl.reg_write     = 1'b1;
                    ctrl.instr_retired = 1'b1;
                end
                BEQ: begin
                    ctrl.alu_src_a     = SRCA_RS1;
                    ctrl.alu_src_b     = SRCB_RS2;
                    ctrl.alu_op        = ALU_SUB;
                    ctrl.result_src    = RES_ALU_OUT;
                    ctrl.pc_write      = zero;
                    ctrl.instr_retired = 1'b1;
                end
                ILLEGAL: ctrl.illegal_instr = 1'b1;
                TIMEOUT: ctrl.mem_timeout   = 1'b1;
                default: ctrl = '0;
            endcase
        end
    end

    assign mem.mem_req    = ctrl.mem_req;
    assign mem.mem_write  = ctrl.mem_write;
    assign adr_src        = ctrl.adr_src;
    assign ir_write       = ctrl.ir_write;
    assign pc_write       = ctrl.pc_write;
    assign reg_write      = ctrl.reg_write;
    assign alu_src_a      = ctrl.alu_src_a;
    assign alu_src_b      = ctrl.alu_src_b;
    assign result_src     = ctrl.result_src;
    assign alu_op         = ctrl.alu_op;
    assign instr_retired  = ctrl.instr_retired;
    assign illegal_instr  = ctrl.illegal_instr;
    assign mem_timeout    = ctrl.mem_timeout;
endmodule

// File: tb/tb_main_control_fsm.sv
// Directed per-cycle vectors for main_control_fsm: default
// timeout instance for sequencing, MEM_TIMEOUT=3 for timeouts.
module tb_main_control_fsm;

    typedef struct packed {
        logic       mr;
        logic       mw;
        logic       as;
        logic       irw;
        logic       pcw;
        logic       rw;
        logic [1:0] sa;
        logic [1:0] sb;
        logic [1:0] rs;
        logic [1:0] ao;
        logic       ret;
        logic       ill;
        logic       tmo;
    } out_t;

    typedef struct {
        logic       rst_n;
        logic [6:0] op;
        logic       zero;
        logic       rdy;
        out_t       exp;
        string      name;
    } vec_t;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] BR  = 7'b1100011;
    localparam logic [6:0] BAD = 7'b0010011;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] op = '0;
    logic       zero = 1'b0;
    logic       rdy1 = 1'b1;
    logic       rdy3 = 1'b1;

    int nvec = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    main_control_fsm_if mif();
    main_control_fsm_if mif3();
    assign mif.mem_ready  = rdy1;
    assign mif3.mem_ready = rdy3;

    logic       as1, irw1, pcw1, rw1, ret1, ill1, tmo1;
    logic [1:0] sa1, sb1, rs1, ao1;
    logic       as3, irw3, pcw3, rw3, ret3, ill3, tmo3;
    logic [1:0] sa3, sb3, rs3, ao3;

    main_control_fsm dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .op           (op),
        .zero         (zero),
        .mem          (mif),
        .adr_src      (as1),
        .ir_write     (irw1),
        .pc_write     (pcw1),
        .reg_write    (rw1),
        .alu_src_a    (sa1),
        .alu_src_b    (sb1),
        .result_src   (rs1),
        .alu_op       (ao1),
        .instr_retired(ret1),
        .illegal_instr(ill1),
        .mem_timeout  (tmo1)
    );

    main_control_fsm #(
        .MEM_TIMEOUT(3)
    ) dut3 (
        .clk          (clk),
        .rst_n        (rst_n),
        .op           (op),
        .zero         (zero),
        .mem          (mif3),
        .adr_src      (as3),
        .ir_write     (irw3),
        .pc_write     (pcw3),
        .reg_write    (rw3),
        .alu_src_a    (sa3),
        .alu_src_b    (sb3),
        .result_src   (rs3),
        .alu_op       (ao3),
        .instr_retired(ret3),
        .illegal_instr(ill3),
        .mem_timeout  (tmo3)
    );

    out_t act1, act3;
    assign act1 = {mif.mem_req, mif.mem_write, as1, irw1, pcw1, rw1,
                   sa1, sb1, rs1, ao1, ret1, ill1, tmo1};
    assign act3 = {mif3.mem_req, mif3.mem_write, as3, irw3, pcw3, rw3,
                   sa3, sb3, rs3, ao3, ret3, ill3, tmo3};

    function automatic out_t o(bit mr, bit mw, bit as, bit irw,
                               bit pcw, bit rw, bit [1:0] sa,
                               bit [1:0] sb, bit [1:0] rs,
                               bit [1:0] ao, bit ret, bit ill,
                               bit tmo);
        out_t r;
        r = '{mr, mw, as, irw, pcw, rw, sa, sb, rs, ao, ret, ill, tmo};
        return r;
    endfunction

    function automatic vec_t mk(bit r, bit [6:0] opc, bit z, bit rd,
                                out_t e, string n);
        vec_t v;
        v.rst_n = r;
        v.op    = opc;
        v.zero  = z;
        v.rdy   = rd;
        v.exp   = e;
        v.name  = n;
        return v;
    endfunction

    vec_t vecs[$];

    task automatic add(bit r, bit [6:0] opc, bit z, bit rd,
                       out_t e, string n);
        vecs.push_back(mk(r, opc, z, rd, e, n));
    endtask

    // Inputs land 1 time unit after a rising edge; outputs are
    // checked on the falling edge, before the next state change.
    task automatic apply(vec_t v, bit use3);
        out_t a;
        rst_n = v.rst_n;
        op    = v.op;
        zero  = v.zero;
        rdy3  = v.rdy;
        rdy1  = use3 ? 1'b1 : v.rdy;
        @(negedge clk);
        a = use3 ? act3 : act1;
        nvec++;
        if (a !== v.exp) begin
            nfail++;
            $display("FAIL %s (vec %0d): got %h, want %h",
                     v.name, nvec, a, v.exp);
        end
        @(posedge clk);
        #1;
    endtask

    out_t ZERO, F_W, F_R, D, MA, MR, MWB, MW_W, MW_R;
    out_t EX, AWB, BT, BN, ILL, TMO;

    initial begin
        ZERO = o(0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 0,0,0);
        F_W  = o(1,0,0,0,0,0, 2'b00,2'b10,2'b10,2'b00, 0,0,0);
        F_R  = o(1,0,0,1,1,0, 2'b00,2'b10,2'b10,2'b00, 0,0,0);
        D    = o(0,0,0,0,0,0, 2'b01,2'b01,2'b00,2'b00, 0,0,0);
        MA   = o(0,0,0,0,0,0, 2'b10,2'b01,2'b00,2'b00, 0,0,0);
        MR   = o(1,0,1,0,0,0, 2'b00,2'b00,2'b00,2'b00, 0,0,0);
        MWB  = o(0,0,0,0,0,1, 2'b00,2'b00,2'b01,2'b00, 1,0,0);
        MW_W = o(1,1,1,0,0,0, 2'b00,2'b00,2'b00,2'b00, 0,0,0);
        MW_R = o(1,1,1,0,0,0, 2'b00,2'b00,2'b00,2'b00, 1,0,0);
        EX   = o(0,0,0,0,0,0, 2'b10,2'b00,2'b00,2'b10, 0,0,0);
        AWB  = o(0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00, 1,0,0);
        BT   = o(0,0,0,0,1,0, 2'b10,2'b00,2'b00,2'b01, 1,0,0);
        BN   = o(0,0,0,0,0,0, 2'b10,2'b00,2'b00,2'b01, 1,0,0);
        ILL  = o(0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 0,1,0);
        TMO  = o(0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 0,0,1);

        for (int i = 0; i < 3; i++) add(0, LW, 0, 1, ZERO, "reset");
        add(1, LW, 0, 1, F_R,  "lw_fetch");
        add(1, LW, 0, 1, D,    "lw_decode");
        add(1, LW, 0, 1, MA,   "lw_memadr");
        add(1, LW, 0, 1, MR,   "lw_memread");
        add(1, LW, 0, 1, MWB,  "lw_memwb");
        add(1, SW, 0, 1, F_R,  "sw_fetch");
        add(1, SW, 0, 1, D,    "sw_decode");
        add(1, SW, 0, 1, MA,   "sw_memadr");
        add(1, SW, 0, 1, MW_R, "sw_memwrite");
        add(1, RT, 0, 1, F_R,  "r_fetch");
        add(1, RT, 0, 0, D,    "r_decode");
        add(1, RT, 0, 0, EX,   "r_execr");
        add(1, RT, 0, 1, AWB,  "r_aluwb");
        add(1, BR, 1, 1, F_R,  "beqt_fetch");
        add(1, BR, 1, 1, D,    "beqt_decode");
        add(1, BR, 1, 1, BT,   "beq_taken");
        add(1, BR, 0, 1, F_R,  "beqn_fetch");
        add(1, BR, 1, 1, D,    "beqn_decode");
        add(1, BR, 0, 1, BN,   "beq_not_taken");
        add(1, RT, 0, 0, F_W,  "fetch_stall");
        add(1, RT, 0, 0, F_W,  "fetch_stall");
        add(1, RT, 0, 1, F_R,  "fetch_go");
        add(1, RT, 0, 1, D,    "r2_decode");
        add(1, RT, 0, 1, EX,   "r2_execr");
        add(1, RT, 0, 1, AWB,  "r2_aluwb");
        add(1, SW, 0, 1, F_R,  "swd_fetch");
        add(1, SW, 0, 1, D,    "swd_decode");
        add(1, SW, 0, 1, MA,   "swd_memadr");
        for (int i = 0; i < 4; i++) add(1, SW, 0, 0, MW_W, "swd_wait");
        add(1, SW, 0, 1, MW_R, "swd_done");
        add(1, LW, 0, 1, F_R,  "abort_fetch");
        add(1, LW, 0, 1, D,    "abort_decode");
        add(1, LW, 0, 1, MA,   "abort_memadr");
        add(1, LW, 0, 0, MR,   "abort_memread");
        add(0, LW, 0, 0, ZERO, "abort_reset");
        add(1, BAD, 0, 1, F_R, "ill_fetch");
        add(1, BAD, 0, 1, D,   "ill_decode");
        for (int i = 0; i < 20; i++)
            add(1, BAD, 1'(i % 3 == 0), 1'(i % 2), ILL, "ill_hold");
        add(0, BAD, 0, 1, ZERO, "ill_reset");
        add(1, LW, 0, 1, F_R,  "ill_cleared");

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], 1'b0);

        apply(mk(0, LW, 0, 0, ZERO, "t3_reset"), 1'b1);
        for (int i = 0; i < 4; i++)
            apply(mk(1, LW, 0, 0, F_W, "t3_fetch_wait"), 1'b1);
        for (int i = 0; i < 3; i++)
            apply(mk(1, LW, 1, 1, TMO, "t3_timeout"), 1'b1);
        apply(mk(0, LW, 0, 0, ZERO, "t3_reset2"), 1'b1);
        for (int i = 0; i < 3; i++)
            apply(mk(1, LW, 0, 0, F_W, "t3_edge_wait"), 1'b1);
        apply(mk(1, LW, 0, 1, F_R, "t3_edge_ready"), 1'b1);
        apply(mk(1, LW, 0, 0, D,   "t3_edge_decode"), 1'b1);
        apply(mk(1, LW, 0, 0, MA,  "t3_memadr"), 1'b1);
        for (int i = 0; i < 3; i++)
            apply(mk(1, LW, 0, 0, MR, "t3_rd_wait"), 1'b1);
        apply(mk(1, LW, 0, 1, MR,  "t3_rd_ready"), 1'b1);
        apply(mk(1, LW, 0, 0, MWB, "t3_memwb"), 1'b1);
        apply(mk(1, LW, 0, 1, F_R, "t3_fetch2"), 1'b1);
        apply(mk(1, LW, 0, 0, D,   "t3_decode2"), 1'b1);
        apply(mk(1, LW, 0, 0, MA,  "t3_memadr2"), 1'b1);
        for (int i = 0; i < 4; i++)
            apply(mk(1, LW, 0, 0, MR, "t3_rd_stall"), 1'b1);
        apply(mk(1, LW, 0, 1, TMO, "t3_rd_timeout"), 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
